// File: rtl/wiper_motor_driver.sv
`default_nettype none
// ============================================================================
//  Module   : wiper_motor_driver
//  Purpose  : Actuator end of the wiper controller. It takes a 2-bit speed
//             command and sweeps a one-hot arm position out to the far end
//             and back again. The step rate depends on the latched speed.
//             When the command drops to off, the arm finishes its current
//             sweep and then parks at position 0.
//  Ports    : clk_2  - single clock, rising edge
//             reset  - asynchronous active-low reset
//             cmd    - speed command (0 off, 1 slow, 2/3 fast)
//             pos    - one-hot arm position, bit0 = park
//             dir    - 0 outward, 1 returning
//             parked - arm at bit0 with the motor idle
//             sweeps - completed out-and-back sweeps, wraps modulo 2^CNT_W
//  Revision : 1.0 - initial release
// ============================================================================
module wiper_motor_driver #(
    parameter int NPOS     = 7,
    parameter int SLOW_DIV = 4,
    parameter int FAST_DIV = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [1:0]       cmd,
    output logic [NPOS-1:0]  pos,
    output logic             dir,
    output logic             parked,
    output logic [CNT_W-1:0] sweeps
);

    // SLOW_DIV is the largest divider, so it sets the width of the tick counter.
    localparam int                TICK_W    = $clog2(SLOW_DIV);
    localparam logic [TICK_W-1:0] SLOW_LAST = TICK_W'(SLOW_DIV - 1);
    localparam logic [TICK_W-1:0] FAST_LAST = TICK_W'(FAST_DIV - 1);
    localparam logic [NPOS-1:0]   POS_PARK  = NPOS'(1);

    typedef enum logic [1:0] {
        ST_PARKED = 2'd0,
        ST_OUT    = 2'd1,
        ST_BACK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NPOS-1:0]    pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               parked_q, parked_d;
    logic [CNT_W-1:0]   sweeps_q, sweeps_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               spd_q, spd_d;      // 0 = slow, 1 = fast
    logic [TICK_W-1:0]  tick_last;
    logic               step;

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_PARKED;
            pos_q    <= POS_PARK;
            dir_q    <= 1'b0;
            parked_q <= 1'b1;
            sweeps_q <= '0;
            tick_q   <= '0;
            spd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            parked_q <= parked_d;
            sweeps_q <= sweeps_d;
            tick_q   <= tick_d;
            spd_q    <= spd_d;
        end
    end

    // The step rate comes from the speed latched at the last step edge, not
    // from the live command.
    assign tick_last = spd_q ? FAST_LAST : SLOW_LAST;
    assign step      = (state_q != ST_PARKED) && (tick_q == tick_last);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        parked_d = parked_q;
        sweeps_d = sweeps_q;
        tick_d   = tick_q;
        spd_d    = spd_q;

        case (state_q)
            ST_PARKED: begin
                if (cmd != 2'd0) begin
                    state_d  = ST_OUT;
                    tick_d   = '0;
                    spd_d    = cmd[1];
                    parked_d = 1'b0;
                end
            end
            ST_OUT, ST_BACK: begin
                tick_d = tick_q + TICK_W'(1);
                if (step) begin
                    tick_d = '0;
                    // An off command keeps the previous speed until parked.
                    if (cmd != 2'd0) begin
                        spd_d = cmd[1];
                    end
                    if (state_q == ST_OUT) begin
                        pos_d = pos_q << 1;
                        if (pos_q[NPOS-2]) begin
                            dir_d   = 1'b1;
                            state_d = ST_BACK;
                        end
                    end else begin
                        pos_d = pos_q >> 1;
                        if (pos_q[1]) begin
                            sweeps_d = sweeps_q + CNT_W'(1);
                            dir_d    = 1'b0;
                            if (cmd == 2'd0) begin
                                state_d  = ST_PARKED;
                                parked_d = 1'b1;
                            end else begin
                                state_d  = ST_OUT;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_PARKED;
                pos_d    = POS_PARK;
                dir_d    = 1'b0;
                parked_d = 1'b1;
                tick_d   = '0;
            end
        endcase
    end

    assign pos    = pos_q;
    assign dir    = dir_q;
    assign parked = parked_q;
    assign sweeps = sweeps_q;

endmodule
`default_nettype wire
